// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with a run/halt FSM and a
// runtime-writable 16-entry branch-target table. The next PC is chosen each
// RUN cycle from halt/stall hold, an absolute table target, a PC-relative
// table offset, or a plain increment.
module pc_sequencer #(
  parameter int D = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stall,
  input  logic         halt,
  input  logic         br_en,
  input  logic         br_abs,
  input  logic [3:0]   br_idx,
  input  logic         cfg_we,
  input  logic [3:0]   cfg_addr,
  input  logic [D-1:0] cfg_data,
  output logic [D-1:0] pc,
  output logic         running,
  output logic         done,
  output logic [15:0]  retired
);

  localparam int TBL_N = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  // Power-on branch-target table contents.
  function automatic logic [D-1:0] tbl_rst_val(input int idx);
    logic [D-1:0] v;
    case (idx)
      1:       v = D'(10);
      2:       v = D'(45);
      3:       v = D'(103);
      4:       v = D'(76);
      5:       v = D'(91);
      6:       v = D'(84);
      7:       v = D'(101);
      8:       v = D'(1);
      9:       v = D'(18);
      default: v = '0;
    endcase
    return v;
  endfunction

  state_e         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic [15:0]    retired_q, retired_d;
  logic [D-1:0]   tbl_q [TBL_N];
  logic [D-1:0]   tbl_d [TBL_N];

  // Branch operand comes from the current (pre-write) table contents, so a
  // same-cycle write to the branched index only shows up next cycle.
  logic [D-1:0]   br_entry;
  assign br_entry = tbl_q[br_idx];

  // Next-state, next-PC and retired-count decision.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    unique case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (stall) begin
          pc_d = pc_q;
        end else begin
          if (br_en && br_abs)  pc_d = br_entry;
          else if (br_en)       pc_d = pc_q + br_entry;  // carry dropped
          else                  pc_d = pc_q + D'(1);
          retired_d = retired_q + 16'd1;                 // wraps at 2^16
        end
      end
      S_HALT: begin
        if (start) begin
          state_d   = S_RUN;
          pc_d      = '0;
          retired_d = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        pc_d      = '0;
        retired_d = '0;
      end
    endcase
  end

  // Table write port: accepted in every state, independent of stall/halt.
  always_comb begin
    for (int i = 0; i < TBL_N; i++) tbl_d[i] = tbl_q[i];
    if (cfg_we) tbl_d[cfg_addr] = cfg_data;
  end

  // Control/PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  // Branch-target table registers; reset restores the power-on contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_N; i++) tbl_q[i] <= tbl_rst_val(i);
    end else begin
      for (int i = 0; i < TBL_N; i++) tbl_q[i] <= tbl_d[i];
    end
  end

  assign pc      = pc_q;
  assign running = (state_q == S_RUN);
  assign done    = (state_q == S_HALT);
  assign retired = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, increment/stall, relative and
// absolute branches with wrap, same-cycle table write, halt priority,
// restart and retired-count wrap.
module tb_pc_sequencer;
  localparam int D = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, stall, halt, br_en, br_abs, cfg_we;
  logic [3:0]   br_idx, cfg_addr;
  logic [D-1:0] cfg_data;
  logic [D-1:0] pc;
  logic         running, done;
  logic [15:0]  retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.D(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
    .br_en(br_en), .br_abs(br_abs), .br_idx(br_idx), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .pc(pc), .running(running),
    .done(done), .retired(retired)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stall = 0; halt = 0; br_en = 0; br_abs = 0; br_idx = 0;
    cfg_we = 0; cfg_addr = 0; cfg_data = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    checks++; if (pc !== 10'd0)    begin errors++; $display("FAIL reset_pc got %0d exp 0", pc); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %0b exp 0", running); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired got %0d exp 0", retired); end
    step();
    rst_n = 1;
    step();
    checks++; if (pc !== 10'd0 || running !== 1'b0) begin errors++; $display("FAIL idle_hold got pc=%0d run=%0b exp pc=0 run=0", pc, running); end
    start = 1; step(); start = 0;
    checks++; if (running !== 1'b1 || pc !== 10'd0) begin errors++; $display("FAIL start_run got pc=%0d run=%0b exp pc=0 run=1", pc, running); end
    // corrupt table[3] then reset mid-run; reset must restore 103
    cfg_we = 1; cfg_addr = 4'd3; cfg_data = 10'd7; step(); cfg_we = 0;
    #2 rst_n = 0;
    #1;
    checks++; if (pc !== 10'd0 || running !== 1'b0 || done !== 1'b0 || retired !== 16'd0) begin
      errors++; $display("FAIL async_reset got pc=%0d run=%0b done=%0b ret=%0d exp all 0", pc, running, done, retired); end
    step(); rst_n = 1;
    start = 1; step(); start = 0;
    br_en = 1; br_abs = 1; br_idx = 4'd3; step(); br_en = 0;
    checks++; if (pc !== 10'd103) begin errors++; $display("FAIL abs_idx3 got %0d exp 103", pc); end
    checks++; if (retired !== 16'd1) begin errors++; $display("FAIL abs_retired got %0d exp 1", retired); end
  endtask

  // Fresh run from reset: five increments, then two stall cycles.
  task automatic test_increment_stall();
    rst_n = 0; #2; rst_n = 1; step();
    start = 1; step(); start = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++; if (pc !== D'(i)) begin errors++; $display("FAIL inc_pc%0d got %0d exp %0d", i, pc, i); end
    end
    checks++; if (retired !== 16'd5) begin errors++; $display("FAIL inc_retired got %0d exp 5", retired); end
    stall = 1; start = 1;  // start is ignored while running
    step(); step();
    stall = 0; start = 0;
    checks++; if (pc !== 10'd5 || retired !== 16'd5) begin
      errors++; $display("FAIL stall_hold got pc=%0d ret=%0d exp pc=5 ret=5", pc, retired); end
  endtask

  // Relative branches with carry discarded: 4+1023=3, 1020+20=16.
  task automatic test_rel_branch();
    halt = 1; step(); halt = 0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_enter got %0b exp 1", done); end
    cfg_we = 1; cfg_addr = 4'd10; cfg_data = 10'd1023; step();
    cfg_addr = 4'd11; cfg_data = 10'd20; step();
    cfg_addr = 4'd12; cfg_data = 10'd1020; step();
    cfg_we = 0;
    checks++; if (pc !== 10'd5 || done !== 1'b1) begin errors++; $display("FAIL halt_cfg_hold got pc=%0d done=%0b exp pc=5 done=1", pc, done); end
    start = 1; step(); start = 0;
    checks++; if (pc !== 10'd0 || retired !== 16'd0) begin errors++; $display("FAIL restart got pc=%0d ret=%0d exp 0 0", pc, retired); end
    repeat (4) step();
    br_en = 1; br_abs = 0; br_idx = 4'd10; step();
    checks++; if (pc !== 10'd3) begin errors++; $display("FAIL rel_neg got %0d exp 3", pc); end
    br_abs = 1; br_idx = 4'd12; step();
    checks++; if (pc !== 10'd1020) begin errors++; $display("FAIL abs_1020 got %0d exp 1020", pc); end
    br_abs = 0; br_idx = 4'd11; step(); br_en = 0;
    checks++; if (pc !== 10'd16) begin errors++; $display("FAIL rel_wrap got %0d exp 16", pc); end
    checks++; if (retired !== 16'd7) begin errors++; $display("FAIL rel_retired got %0d exp 7", retired); end
  endtask

  // Write and branch to the same index in one cycle reads the old entry.
  task automatic test_same_cycle_write();
    cfg_we = 1; cfg_addr = 4'd2; cfg_data = 10'd500;
    br_en = 1; br_abs = 1; br_idx = 4'd2; step();
    cfg_we = 0;
    checks++; if (pc !== 10'd45) begin errors++; $display("FAIL same_cycle_old got %0d exp 45", pc); end
    step(); br_en = 0;
    checks++; if (pc !== 10'd500) begin errors++; $display("FAIL same_cycle_new got %0d exp 500", pc); end
  endtask

  // halt beats stall and branch; start from HALT clears pc and retired.
  task automatic test_halt();
    halt = 1; step(); halt = 0;
    start = 1; step(); start = 0;
    repeat (7) step();
    checks++; if (pc !== 10'd7 || retired !== 16'd7) begin errors++; $display("FAIL pre_halt got pc=%0d ret=%0d exp 7 7", pc, retired); end
    halt = 1; stall = 1; br_en = 1; br_abs = 1; br_idx = 4'd3; step();
    halt = 0; stall = 0; br_en = 0;
    checks++; if (done !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL halt_state got done=%0b run=%0b exp 1 0", done, running); end
    checks++; if (pc !== 10'd7 || retired !== 16'd7) begin errors++; $display("FAIL halt_hold got pc=%0d ret=%0d exp 7 7", pc, retired); end
    step();
    checks++; if (pc !== 10'd7 || done !== 1'b1) begin errors++; $display("FAIL halt_stay got pc=%0d done=%0b exp 7 1", pc, done); end
    start = 1; step(); start = 0;
    checks++; if (pc !== 10'd0 || retired !== 16'd0 || running !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL halt_restart got pc=%0d ret=%0d run=%0b done=%0b exp 0 0 1 0", pc, retired, running, done); end
  endtask

  // PC wraps 1023->0; retired wraps 65535->0.
  task automatic test_wrap();
    br_en = 1; br_abs = 1; br_idx = 4'd12; step(); br_en = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (pc !== D'((1020 + i) % 1024)) begin errors++; $display("FAIL pc_wrap%0d got %0d exp %0d", i, pc, (1020 + i) % 1024); end
    end
    checks++; if (retired !== 16'd5) begin errors++; $display("FAIL wrap_retired got %0d exp 5", retired); end
    repeat (65530) step();
    checks++; if (retired !== 16'd65535) begin errors++; $display("FAIL ret_max got %0d exp 65535", retired); end
    step();
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL ret_wrap got %0d exp 0", retired); end
  endtask

  initial begin
    test_reset();
    test_increment_stall();
    test_rel_branch();
    test_same_cycle_write();
    test_halt();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the core's fetch stage. It owns the PC register, a run/halt state machine and a runtime-writable 16-entry branch-target table. Each cycle it selects the next PC from increment, absolute table target or PC-relative table offset. It sits between the decoder's branch/halt controls and instruction-memory address.

## Interface
- D, 10, PC width; table entry width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE/HALT and begin execution at PC 0
- stall  in  1  hold PC this cycle (RUN only)
- halt  in  1  decoder saw halt instruction; stop
- br_en  in  1  branch taken this cycle
- br_abs  in  1  1: next PC = table entry; 0: next PC = PC + entry (entry as signed D-bit)
- br_idx  in  4  table index for branch
- cfg_we  in  1  table write strobe
- cfg_addr  in  4  table write index
- cfg_data  in  D  table write data
- pc  out  D  current PC (registered)
- running  out  1  state == RUN
- done  out  1  state == HALT
- retired  out  16  count of PC-advancing RUN cycles (registered)

## Operation
- States: IDLE, RUN, HALT. Reset → IDLE.
- IDLE: pc held at 0. start=1 → RUN, pc←0.
- RUN, priority high→low per cycle:
  - halt=1 → HALT; pc holds; retired holds.
  - stall=1 → pc holds; retired holds.
  - br_en=1, br_abs=1 → pc←table[br_idx]; retired+1.
  - br_en=1, br_abs=0 → pc←(pc + table[br_idx]) mod 2^D; retired+1.
  - otherwise pc←(pc+1) mod 2^D; retired+1.
  - start ignored in RUN.
- HALT: pc, retired hold. start=1 → RUN, pc←0, retired←0.
- Arithmetic: D-bit two's-complement add, carry discarded (e.g. 4 + 1023 = 3; 1020 + 20 = 16). pc 2^D−1 increments to 0.
- retired: 16-bit, wraps 65535→0; cleared only by reset and by start from HALT (not from IDLE; already 0).
- Table: 16 × D registers. Reset contents: [0]=0, [1]=10, [2]=45, [3]=103, [4]=76, [5]=91, [6]=84, [7]=101, [8]=1, [9]=18, [10..15]=0.
- cfg_we=1 writes cfg_data to table[cfg_addr] at the clock edge, in any state, including during stall/halt.
- Read is combinational from current table contents; a write and a branch to the same index in the same cycle use the OLD entry; new value visible from the next cycle.
- br_idx, br_abs, br_en are don't-care outside RUN and when halt or stall is 1.

## Timing
- Reset (async assert, sync-safe release): pc=0, state=IDLE, running=0, done=0, retired=0, table=reset contents. Assertion mid-RUN clears all immediately, including table writes.
- All outputs registered or decoded from registered state; no combinational input→output paths.
- start sampled at edge t → running=1, pc=0 after t; first advance at edge t+1.
- Branch/increment: next-PC decision at edge t visible on pc after t (1-cycle latency).
- halt at edge t → done=1, running=0 after t; pc keeps value from before t.
- start and halt never both act in one cycle: start only acts in IDLE/HALT, halt only in RUN.

## Test plan
- Reset with rst_n=0 mid-cycle → pc=0, running=0, done=0, retired=0 asynchronously; after release, br_abs branch on idx 3 (once running) yields 103.
- start, then 5 idle cycles → pc 0,1,2,3,4,5; retired=5; stall=1 for 2 cycles → pc stays 5, retired 5.
- At pc=4, br_en=1, br_abs=0, cfg-written table[10]=1023 → pc=3; at pc=1020 with table[11]=20 → pc=16.
- Same cycle: cfg_we to idx 2 with 500 and br_en abs idx 2 → pc=45; next branch on idx 2 → pc=500.
- halt=1 with stall=1 and br_en=1 at pc=7 → done=1, pc=7, retired unchanged; start → pc=0, retired=0, running=1.
- Free-run from pc 1020 → 1021,1022,1023,0; retired preset near 65535 via long run wraps to 0.
